// File: rtl/alu_result_router_pkg.sv
// Shared encodings for the ALU result router: route selects, FSM states and datapath width.
package alu_result_router_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ROUTE_RF    = 2'h0;
  localparam logic [1:0] ROUTE_STORE = 2'h1;
  localparam logic [1:0] ROUTE_LOAD  = 2'h2;
  localparam logic [1:0] ROUTE_PC    = 2'h3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_LWAIT = 2'd2;

endpackage

// File: rtl/alu_result_router.sv
// Routes the ALU result to the register file, the LSU (single outstanding request) or a PC redirect,
// and writes load data back to the register file.
module alu_result_router
  import alu_result_router_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [XLEN-1:0] io_alu_out,
  input  logic [XLEN-1:0] io_rs2,
  input  logic [4:0]      io_rd,
  input  logic [1:0]      io_route_sel,
  output logic            io_rf_wen,
  output logic [4:0]      io_rf_waddr,
  output logic [XLEN-1:0] io_rf_wdata,
  output logic            io_lsu_req_valid,
  input  logic            io_lsu_req_ready,
  output logic            io_lsu_we,
  output logic [XLEN-1:0] io_lsu_addr,
  output logic [XLEN-1:0] io_lsu_wdata,
  input  logic            io_lsu_rvalid,
  input  logic [XLEN-1:0] io_lsu_rdata,
  output logic            io_pc_redirect_valid,
  output logic [XLEN-1:0] io_pc_target
);

  logic [1:0] state;
  logic [4:0] load_rd;
  logic       accept;

  assign io_in_ready = (state == ST_IDLE);
  assign accept      = io_in_valid && io_in_ready;

  // Single-cycle pulses (rf_wen, pc_redirect_valid) default low; LSU payload holds until handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= ST_IDLE;
      load_rd              <= 5'd0;
      io_rf_wen            <= 1'b0;
      io_rf_waddr          <= 5'd0;
      io_rf_wdata          <= '0;
      io_lsu_req_valid     <= 1'b0;
      io_lsu_we            <= 1'b0;
      io_lsu_addr          <= '0;
      io_lsu_wdata         <= '0;
      io_pc_redirect_valid <= 1'b0;
      io_pc_target         <= '0;
    end else begin
      io_rf_wen            <= 1'b0;
      io_pc_redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (io_route_sel)
              ROUTE_RF: begin
                io_rf_wen   <= (io_rd != 5'd0);
                io_rf_waddr <= io_rd;
                io_rf_wdata <= io_alu_out;
              end
              ROUTE_PC: begin
                io_pc_redirect_valid <= 1'b1;
                io_pc_target         <= {io_alu_out[XLEN-1:1], 1'b0};
              end
              ROUTE_STORE: begin
                io_lsu_req_valid <= 1'b1;
                io_lsu_we        <= 1'b1;
                io_lsu_addr      <= io_alu_out;
                io_lsu_wdata     <= io_rs2;
                state            <= ST_REQ;
              end
              default: begin
                io_lsu_req_valid <= 1'b1;
                io_lsu_we        <= 1'b0;
                io_lsu_addr      <= io_alu_out;
                load_rd          <= io_rd;
                state            <= ST_REQ;
              end
            endcase
          end
        end
        ST_REQ: begin
          if (io_lsu_req_ready) begin
            io_lsu_req_valid <= 1'b0;
            state            <= io_lsu_we ? ST_IDLE : ST_LWAIT;
          end
        end
        ST_LWAIT: begin
          if (io_lsu_rvalid) begin
            io_rf_wen   <= (load_rd != 5'd0);
            io_rf_waddr <= load_rd;
            io_rf_wdata <= io_lsu_rdata;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_router.sv
// Directed self-checking bench for alu_result_router: inputs change 1 time unit after the rising edge,
// outputs are sampled at that same point.
module tb_alu_result_router;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_alu_out;
  logic [31:0] io_rs2;
  logic [4:0]  io_rd;
  logic [1:0]  io_route_sel;
  logic        io_rf_wen;
  logic [4:0]  io_rf_waddr;
  logic [31:0] io_rf_wdata;
  logic        io_lsu_req_valid;
  logic        io_lsu_req_ready;
  logic        io_lsu_we;
  logic [31:0] io_lsu_addr;
  logic [31:0] io_lsu_wdata;
  logic        io_lsu_rvalid;
  logic [31:0] io_lsu_rdata;
  logic        io_pc_redirect_valid;
  logic [31:0] io_pc_target;

  int checks;
  int errors;

  alu_result_router dut (
    .clock                (clock),
    .reset                (reset),
    .io_in_valid          (io_in_valid),
    .io_in_ready          (io_in_ready),
    .io_alu_out           (io_alu_out),
    .io_rs2               (io_rs2),
    .io_rd                (io_rd),
    .io_route_sel         (io_route_sel),
    .io_rf_wen            (io_rf_wen),
    .io_rf_waddr          (io_rf_waddr),
    .io_rf_wdata          (io_rf_wdata),
    .io_lsu_req_valid     (io_lsu_req_valid),
    .io_lsu_req_ready     (io_lsu_req_ready),
    .io_lsu_we            (io_lsu_we),
    .io_lsu_addr          (io_lsu_addr),
    .io_lsu_wdata         (io_lsu_wdata),
    .io_lsu_rvalid        (io_lsu_rvalid),
    .io_lsu_rdata         (io_lsu_rdata),
    .io_pc_redirect_valid (io_pc_redirect_valid),
    .io_pc_target         (io_pc_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] sel, input logic [31:0] alu,
                               input logic [31:0] rs2, input logic [4:0] rd);
    io_in_valid  = valid;
    io_route_sel = sel;
    io_alu_out   = alu;
    io_rs2       = rs2;
    io_rd        = rd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    io_lsu_req_ready = 1'b0;
    io_lsu_rvalid    = 1'b0;
    io_lsu_rdata     = 32'h0;

    // Reset values
    #3;
    checkOutput("reset_in_ready",   io_in_ready, 32'd1);
    checkOutput("reset_rf_wen",     io_rf_wen, 32'd0);
    checkOutput("reset_rf_waddr",   io_rf_waddr, 32'd0);
    checkOutput("reset_rf_wdata",   io_rf_wdata, 32'd0);
    checkOutput("reset_req_valid",  io_lsu_req_valid, 32'd0);
    checkOutput("reset_lsu_we",     io_lsu_we, 32'd0);
    checkOutput("reset_lsu_addr",   io_lsu_addr, 32'd0);
    checkOutput("reset_lsu_wdata",  io_lsu_wdata, 32'd0);
    checkOutput("reset_pc_valid",   io_pc_redirect_valid, 32'd0);
    checkOutput("reset_pc_target",  io_pc_target, 32'd0);
    stepCycle();
    reset = 1'b1;
    stepCycle();

    // RF route, rd=5
    applyStimulus(1'b1, 2'd0, 32'h0000_1234, 32'h0, 5'd5);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    checkOutput("rf_wen",   io_rf_wen, 32'd1);
    checkOutput("rf_waddr", io_rf_waddr, 32'd5);
    checkOutput("rf_wdata", io_rf_wdata, 32'h0000_1234);
    stepCycle();
    checkOutput("rf_wen_pulse_end", io_rf_wen, 32'd0);

    // RF route, rd=0 never writes
    applyStimulus(1'b1, 2'd0, 32'h0000_5678, 32'h0, 5'd0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    checkOutput("rf_rd0_wen", io_rf_wen, 32'd0);
    checkOutput("rf_rd0_in_ready", io_in_ready, 32'd1);

    // PC route clears bit 0
    applyStimulus(1'b1, 2'd3, 32'h8000_0103, 32'h0, 5'd0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    checkOutput("pc_valid",  io_pc_redirect_valid, 32'd1);
    checkOutput("pc_target", io_pc_target, 32'h8000_0102);
    checkOutput("pc_no_rf",  io_rf_wen, 32'd0);
    stepCycle();
    checkOutput("pc_valid_pulse_end", io_pc_redirect_valid, 32'd0);

    // Store with 3 cycles of backpressure; payload must hold while inputs change
    applyStimulus(1'b1, 2'd1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd0, 32'h5555_0000 + i, 32'h1234_0000 + i, 5'd3);
      checkOutput("st_req_valid", io_lsu_req_valid, 32'd1);
      checkOutput("st_we",        io_lsu_we, 32'd1);
      checkOutput("st_addr",      io_lsu_addr, 32'h0000_0100);
      checkOutput("st_wdata",     io_lsu_wdata, 32'hDEAD_BEEF);
      checkOutput("st_in_ready",  io_in_ready, 32'd0);
      checkOutput("st_no_rf",     io_rf_wen, 32'd0);
      if (i < 2) stepCycle();
    end
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    io_lsu_req_ready = 1'b1;
    stepCycle();
    io_lsu_req_ready = 1'b0;
    checkOutput("st_done_req_valid", io_lsu_req_valid, 32'd0);
    checkOutput("st_done_in_ready",  io_in_ready, 32'd1);

    // Load, ready immediately, rvalid on the second LWAIT cycle
    io_lsu_req_ready = 1'b1;
    applyStimulus(1'b1, 2'd2, 32'h0000_0200, 32'h0, 5'd7);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    checkOutput("ld_req_valid", io_lsu_req_valid, 32'd1);
    checkOutput("ld_we",        io_lsu_we, 32'd0);
    checkOutput("ld_addr",      io_lsu_addr, 32'h0000_0200);
    stepCycle();
    io_lsu_req_ready = 1'b0;
    checkOutput("ld_hs_req_valid", io_lsu_req_valid, 32'd0);
    checkOutput("ld_lwait_in_ready", io_in_ready, 32'd0);
    stepCycle();
    checkOutput("ld_wait_no_wen", io_rf_wen, 32'd0);
    io_lsu_rvalid = 1'b1;
    io_lsu_rdata  = 32'hCAFE_F00D;
    stepCycle();
    io_lsu_rvalid = 1'b0;
    io_lsu_rdata  = 32'h0;
    checkOutput("ld_wb_wen",   io_rf_wen, 32'd1);
    checkOutput("ld_wb_waddr", io_rf_waddr, 32'd7);
    checkOutput("ld_wb_wdata", io_rf_wdata, 32'hCAFE_F00D);
    checkOutput("ld_wb_in_ready", io_in_ready, 32'd1);
    stepCycle();
    checkOutput("ld_wb_pulse_end", io_rf_wen, 32'd0);

    // Spurious rvalid while idle
    io_lsu_rvalid = 1'b1;
    io_lsu_rdata  = 32'h1111_2222;
    stepCycle();
    io_lsu_rvalid = 1'b0;
    checkOutput("spurious_rvalid_wen", io_rf_wen, 32'd0);

    // Back-to-back RF routes
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd0, 32'h0000_A000 + i, 32'h0, 5'(i + 1));
      stepCycle();
      checkOutput("b2b_wen",   io_rf_wen, 32'd1);
      checkOutput("b2b_waddr", io_rf_waddr, 32'(i + 1));
      checkOutput("b2b_wdata", io_rf_wdata, 32'h0000_A000 + i);
    end
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    stepCycle();
    checkOutput("b2b_end_wen", io_rf_wen, 32'd0);

    // Reset asserted during LWAIT
    io_lsu_req_ready = 1'b1;
    applyStimulus(1'b1, 2'd2, 32'h0000_0300, 32'h0, 5'd9);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    stepCycle();
    io_lsu_req_ready = 1'b0;
    checkOutput("rst_lwait_pre_in_ready", io_in_ready, 32'd0);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_lwait_req_valid", io_lsu_req_valid, 32'd0);
    checkOutput("rst_lwait_wen",       io_rf_wen, 32'd0);
    checkOutput("rst_lwait_in_ready",  io_in_ready, 32'd1);
    #2 reset = 1'b1;
    stepCycle();
    io_lsu_rvalid = 1'b1;
    io_lsu_rdata  = 32'h3333_4444;
    stepCycle();
    io_lsu_rvalid = 1'b0;
    checkOutput("rst_lwait_late_rvalid_wen", io_rf_wen, 32'd0);

    // Reset asserted during REQ drops req_valid asynchronously
    applyStimulus(1'b1, 2'd1, 32'h0000_0400, 32'h0BAD_F00D, 5'd0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    checkOutput("rst_req_pre_valid", io_lsu_req_valid, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_req_valid",    io_lsu_req_valid, 32'd0);
    checkOutput("rst_req_in_ready", io_in_ready, 32'd1);
    checkOutput("rst_req_addr",     io_lsu_addr, 32'd0);
    #2 reset = 1'b1;
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
